// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter: N_REQ requesters into one registered output beat.
// Optional per-packet grant locking is enabled with `define ARB_PKT_LOCK_EN.
module stream_rr_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_REQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out,
  output logic                    last_out,
  output logic [2:0]              src_out,
  input  logic                    ready_in,
  output logic [15:0]             beat_cnt
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  ptr;
  logic              load_en;
  logic              rr_any;
  logic [PTR_W-1:0]  rr_idx;
  logic              gnt_any;
  logic [PTR_W-1:0]  gnt_idx;
  logic [N_REQ-1:0]  grant;
  logic              accept;
  logic              ptr_upd;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic [DATA_W-1:0] data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  assign load_en = !valid_out || ready_in;

  // Rotating-priority search starting just after the last granted requester.
  always_comb begin
    int unsigned j;
    j      = 0;
    rr_any = 1'b0;
    rr_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!rr_any && req_valid[PTR_W'(j)]) begin
        rr_any = 1'b1;
        rr_idx = PTR_W'(j);
      end
    end
  end

`ifdef ARB_PKT_LOCK_EN
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t      state;
  logic [PTR_W-1:0] lock_idx;

  // While a packet is open only its owner may be granted.
  always_comb begin
    gnt_any = rr_any;
    gnt_idx = rr_idx;
    if (state == LOCKED) begin
      gnt_any = req_valid[lock_idx];
      gnt_idx = lock_idx;
    end
  end

  assign ptr_upd = accept && sel_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= UNLOCKED;
      lock_idx <= '0;
    end else begin
      case (state)
        UNLOCKED: if (accept && !sel_last) begin
          state    <= LOCKED;
          lock_idx <= gnt_idx;
        end
        LOCKED: if (accept && sel_last) state <= UNLOCKED;
        default: state <= UNLOCKED;
      endcase
    end
  end
`else
  assign gnt_any = rr_any;
  assign gnt_idx = rr_idx;
  assign ptr_upd = accept;
`endif

  assign grant     = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
  assign req_ready = rst ? '0 : (grant & {N_REQ{load_en}});
  assign accept    = !rst && load_en && gnt_any;
  assign sel_data  = data_arr[gnt_idx];
  assign sel_last  = req_last[gnt_idx];

  // Output register, transfer counter and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      last_out  <= 1'b0;
      src_out   <= '0;
      beat_cnt  <= '0;
      ptr       <= PTR_W'(N_REQ - 1);
    end else begin
      if (valid_out && ready_in) beat_cnt <= beat_cnt + 16'd1;
      if (load_en) begin
        if (gnt_any) begin
          data_out  <= sel_data;
          last_out  <= sel_last;
          src_out   <= 3'(gnt_idx);
          valid_out <= 1'b1;
        end else begin
          valid_out <= 1'b0;
        end
      end
      if (ptr_upd) ptr <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: vector table, directed sequences and a beat scoreboard
// against a cycle-level reference model (lock checks active with ARB_PKT_LOCK_EN).
module tb_stream_rr_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0]    data_out;
  logic             valid_out, last_out, ready_in;
  logic [2:0]       src_out;
  logic [15:0]      beat_cnt;

  always #5 clk = ~clk;

  stream_rr_arbiter #(.DATA_W(DW), .N_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .data_out(data_out),
    .valid_out(valid_out), .last_out(last_out), .src_out(src_out),
    .ready_in(ready_in), .beat_cnt(beat_cnt)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [2:0] src;
  } beat_t;

  typedef struct packed {
    logic [3:0] rv;
    logic       rdy;
    logic [3:0] exp_rdy;
    logic       exp_v;
    logic [2:0] exp_src;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  beat_t       sb[$];
  logic        m_valid;
  logic [15:0] m_cnt;
  int          m_ptr;
  logic        m_lock;
  int          m_lidx;
  logic [3:0]  got_rdy;
  vec_t        tbl [14];
  logic [31:0] d;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic int pick(logic [3:0] v);
    if (m_lock) return v[m_lidx] ? m_lidx : -1;
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pat(int seed);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'((i << 4) | (seed & 15));
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_cnt   = '0;
    m_ptr   = 3;
    m_lock  = 1'b0;
    m_lidx  = 0;
    sb.delete();
  endtask

  // One clock cycle: drive at negedge, check handshake, update model at posedge.
  task automatic step(input logic [3:0] rv, input logic [3:0] rl,
                      input logic [31:0] dat, input logic rdy);
    int    p;
    logic  ld;
    beat_t b, e;
    req_valid = rv; req_last = rl; req_data = dat; ready_in = rdy;
    #1;
    ld      = !m_valid || rdy;
    p       = ld ? pick(rv) : -1;
    got_rdy = req_ready;
    check("req_ready", 32'(req_ready), (p >= 0) ? (32'(1) << p) : 32'(0));
    if (valid_out && ready_in) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty: got unexpected beat src %0d expected none", src_out);
      end else begin
        e = sb.pop_front();
        b = {data_out, last_out, src_out};
        check("beat", 32'(b), 32'(e));
      end
    end
    if (p >= 0) begin
      b.data = dat[p*8 +: 8];
      b.last = rl[p];
      b.src  = 3'(p);
      sb.push_back(b);
    end
    @(posedge clk);
    if (m_valid && rdy) m_cnt++;
    if (ld) m_valid = (p >= 0);
    if (p >= 0) begin
`ifdef ARB_PKT_LOCK_EN
      if (!m_lock && !rl[p]) begin
        m_lock = 1'b1;
        m_lidx = p;
      end else if (rl[p]) begin
        m_lock = 1'b0;
        m_ptr  = p;
      end
`else
      m_ptr = p;
`endif
    end
    @(negedge clk);
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    cyc++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{4'b1111, 1'b1, 4'b0001, 1'b1, 3'd0},
      '{4'b1111, 1'b1, 4'b0010, 1'b1, 3'd1},
      '{4'b1111, 1'b1, 4'b0100, 1'b1, 3'd2},
      '{4'b1111, 1'b1, 4'b1000, 1'b1, 3'd3},
      '{4'b1111, 1'b1, 4'b0001, 1'b1, 3'd0},
      '{4'b1111, 1'b1, 4'b0010, 1'b1, 3'd1},
      '{4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0},
      '{4'b1010, 1'b1, 4'b1000, 1'b1, 3'd3},
      '{4'b1010, 1'b1, 4'b0010, 1'b1, 3'd1},
      '{4'b1010, 1'b1, 4'b1000, 1'b1, 3'd3},
      '{4'b0110, 1'b1, 4'b0010, 1'b1, 3'd1},
      '{4'b0101, 1'b1, 4'b0100, 1'b1, 3'd2},
      '{4'b1001, 1'b1, 4'b1000, 1'b1, 3'd3},
      '{4'b0000, 1'b1, 4'b0000, 1'b0, 3'd0}
    };

    // Reset state, with requests pending during reset.
    rst = 1'b1; req_valid = 4'b1111; req_last = '0; req_data = '0; ready_in = 1'b1;
    model_reset();
    #2;
    check("rst_valid", 32'(valid_out), 32'(0));
    check("rst_data", 32'(data_out), 32'(0));
    check("rst_last", 32'(last_out), 32'(0));
    check("rst_src", 32'(src_out), 32'(0));
    check("rst_cnt", 32'(beat_cnt), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Round robin, drain, skip patterns.
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rv, 4'hF, pat(cyc), tbl[i].rdy);
      check("tbl_ready", 32'(got_rdy), 32'(tbl[i].exp_rdy));
      check("tbl_valid", 32'(valid_out), 32'(tbl[i].exp_v));
      if (tbl[i].exp_v) check("tbl_src", 32'(src_out), 32'(tbl[i].exp_src));
      if (i == 6) check("rr_cnt6", 32'(beat_cnt), 32'(6));
    end

    // Backpressure holds the beat and blocks all requesters.
    d = pat(cyc); d[7:0] = 8'hA5;
    step(4'b0001, 4'hF, d, 1'b1);
    check("bp_load", 32'(data_out), 32'hA5);
    d[7:0] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 4'hF, d, 1'b0);
      check("bp_ready", 32'(got_rdy), 32'(0));
      check("bp_hold", 32'(data_out), 32'hA5);
      check("bp_valid", 32'(valid_out), 32'(1));
    end
    step(4'b0001, 4'hF, d, 1'b1);
    check("bp_release_ready", 32'(got_rdy), 32'b0001);
    check("bp_next", 32'(data_out), 32'h5A);
    step(4'b0000, 4'hF, pat(cyc), 1'b1);

`ifdef ARB_PKT_LOCK_EN
    // Packet from requester 2 keeps the grant while requester 0 waits.
    step(4'b0010, 4'hF, pat(cyc), 1'b1);
    check("lk_src1", 32'(src_out), 32'(1));
    step(4'b0101, 4'b0000, pat(cyc), 1'b1);
    check("lk_src_a", 32'(src_out), 32'(2));
    step(4'b0101, 4'b0000, pat(cyc), 1'b1);
    check("lk_src_b", 32'(src_out), 32'(2));
    step(4'b0101, 4'b0100, pat(cyc), 1'b1);
    check("lk_src_c", 32'(src_out), 32'(2));
    check("lk_last", 32'(last_out), 32'(1));
    step(4'b0101, 4'b0001, pat(cyc), 1'b1);
    check("lk_src_d", 32'(src_out), 32'(0));
    step(4'b0000, 4'hF, pat(cyc), 1'b1);
    // Owner idle mid-packet: nobody else is granted.
    step(4'b0100, 4'b0000, pat(cyc), 1'b1);
    step(4'b0001, 4'b0000, pat(cyc), 1'b1);
    check("lk_gap_ready", 32'(got_rdy), 32'(0));
    step(4'b0100, 4'b0100, pat(cyc), 1'b1);
    check("lk_gap_src", 32'(src_out), 32'(2));
    step(4'b0000, 4'hF, pat(cyc), 1'b1);
`endif

    // Reset while a beat is held.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) step(4'b1111, 4'hF, pat(cyc), 1'b1);
    check("mid_cnt5", 32'(beat_cnt), 32'(5));
    #2;
    rst = 1'b1;
    #1;
    check("mid_valid", 32'(valid_out), 32'(0));
    check("mid_cnt", 32'(beat_cnt), 32'(0));
    check("mid_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b1111, 4'hF, pat(cyc), 1'b1);
    check("mid_first", 32'(got_rdy), 32'b0001);

    // Counter wrap.
    for (int i = 0; i < 65535; i++) step(4'b1111, 4'hF, pat(cyc), 1'b1);
    check("wrap_ffff", 32'(beat_cnt), 32'hFFFF);
    step(4'b1111, 4'hF, pat(cyc), 1'b1);
    check("wrap_zero", 32'(beat_cnt), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the beat data width.
REQ-002 Parameter N_REQ, default 4, SHALL set the requester count; the legal range is 2..8.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 req_valid  input  N_REQ  SHALL carry one valid bit per requester.
REQ-006 req_data  input  N_REQ*DATA_W  SHALL carry requester i's beat in slice [i*DATA_W +: DATA_W].
REQ-007 req_last  input  N_REQ  SHALL mark the last beat of a packet, per requester.
REQ-008 req_ready  output  N_REQ  SHALL signal that requester i's beat is accepted in this cycle.
REQ-009 data_out  output  DATA_W  SHALL carry the registered output beat.
REQ-010 valid_out  output  1  SHALL indicate that data_out holds a beat.
REQ-011 last_out  output  1  SHALL carry the registered req_last of the output beat.
REQ-012 src_out  output  3  SHALL carry the index of the requester that supplied the output beat.
REQ-013 ready_in  input  1  SHALL signal that the downstream sink accepts the beat this cycle.
REQ-014 beat_cnt  output  16  SHALL count accepted output beats.

Function
REQ-015 An output transfer SHALL occur when valid_out=1 and ready_in=1 in the same cycle.
REQ-016 load_en SHALL equal (!valid_out || ready_in), so that back-to-back transfers sustain one beat per cycle.
REQ-017 The grant SHALL be combinational and one-hot: the first i with req_valid[i]=1, searched from (ptr+1) mod N_REQ upward with wrap-around.
REQ-018 req_ready[i] SHALL equal grant[i] && load_en; at most one bit of req_ready SHALL be set in any cycle.
REQ-019 On an accepted beat (req_valid[i] && req_ready[i]), the block SHALL load req_data/req_last slice i into data_out/last_out, load src_out=i, and set valid_out=1 on the next edge.
REQ-020 Input-to-output latency SHALL be exactly 1 cycle.
REQ-021 When load_en=1 and no request is valid, valid_out SHALL clear to 0 on the next edge.
REQ-022 When load_en=0 (stall), data_out, last_out, src_out and valid_out SHALL hold their values, and req_ready SHALL be all zero.
REQ-023 ptr SHALL update to the granted index on each accepted beat; ptr SHALL hold in all other cycles.
REQ-024 A requester that deasserts req_valid while ungranted SHALL be skipped with no penalty.
REQ-025 beat_cnt SHALL increment by 1 on each output transfer and SHALL wrap from 0xFFFF to 0x0000.
REQ-026 When a new beat loads in the same cycle an output transfer completes, the transfer SHALL be counted and the new beat SHALL be presented, with no bubble.

Reset
REQ-027 Asserting rst SHALL immediately set valid_out=0, data_out=0, last_out=0, src_out=0, beat_cnt=0, ptr=N_REQ-1 and lock state=UNLOCKED.
REQ-028 req_ready SHALL be all zero while rst=1.
REQ-029 A beat held in the output register when rst asserts SHALL be discarded.
REQ-030 After rst deasserts, the first grant SHALL go to the lowest-indexed valid requester.

Configuration
REQ-031 With macro ARB_PKT_LOCK_EN defined, the block SHALL implement a two-state machine UNLOCKED/LOCKED:
- UNLOCKED->LOCKED when a beat with req_last=0 is accepted; the block SHALL latch lock_idx to that requester.
- In LOCKED, grant SHALL be forced to lock_idx regardless of other requests; when req_valid[lock_idx]=0, no requester SHALL be granted.
- LOCKED->UNLOCKED when a beat from lock_idx with req_last=1 is accepted.
- ptr SHALL update only on the beat that returns the machine to UNLOCKED.
REQ-032 Without ARB_PKT_LOCK_EN, the lock state SHALL not exist, arbitration SHALL be per beat, and req_last SHALL only be forwarded to last_out.

Verification
REQ-033 Round-robin: all 4 requesters hold valid=1, ready_in=1 -> src_out sequence 0,1,2,3,0,1 on consecutive cycles, and beat_cnt=6 after 6 transfers.
REQ-034 Backpressure: beat 0xA5 loaded, ready_in=0 for 3 cycles -> data_out=0xA5 and valid_out=1 held, req_ready=0000; ready_in=1 -> transfer, and the next beat appears 1 cycle later.
REQ-035 Skip: only requesters 1 and 3 valid, ptr=1 -> grant 3, then 1, then 3.
REQ-036 Packet lock (macro defined): requester 2 sends 3 beats with last on the 3rd while requester 0 is valid throughout -> src_out=2,2,2, then 0.
REQ-037 Reset mid-operation: rst asserted while valid_out=1 and beat_cnt=5 -> same cycle valid_out=0 and beat_cnt=0; after release, the first grant goes to requester 0.
REQ-038 Wrap: preload 0xFFFF transfers -> one more transfer makes beat_cnt=0x0000.
